// File: rtl/map_mem_arbiter.sv
// Single-port arbiter for the world-map cell RAM: VGA reads take priority,
// robot reads/writes get through via a starvation counter.
module map_mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 3,
  parameter int STARVE_MAX = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_valid,
  output logic              vga_overrun,
  input  logic              bot_req,
  input  logic              bot_we,
  input  logic [ADDR_W-1:0] bot_addr,
  input  logic [DATA_W-1:0] bot_wdata,
  output logic              bot_ack,
  output logic [DATA_W-1:0] bot_rdata,
  output logic              bot_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_BOT  = 2'd2
  } owner_t;

  logic              pend_vga;
  logic [ADDR_W-1:0] pend_addr;
  logic [CNT_W-1:0]  starve_cnt;
  owner_t            owner_p1;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] vga_hold;
  logic [DATA_W-1:0] bot_hold;
  logic              overrun;
  logic              starved;
  logic              issue_vga;
  logic              issue_bot;

  // Issue slot: reset gates the combinational grants so every output is 0 while held.
  always_comb begin
    starved   = bot_req && (starve_cnt == CNT_MAX);
    issue_bot = !reset && bot_req && (starved || !pend_vga);
    issue_vga = !reset && pend_vga && !starved;
  end

  assign bot_ack     = issue_bot;
  assign mem_we      = issue_bot && bot_we;
  assign mem_wdata   = (issue_bot && bot_we) ? bot_wdata : '0;
  assign mem_addr    = issue_vga ? pend_addr : (issue_bot ? bot_addr : last_addr);
  assign vga_overrun = overrun;

  // Response stage: owner tag from last cycle steers the RAM read data.
  assign vga_valid  = (owner_p1 == OWN_VGA);
  assign bot_rvalid = (owner_p1 == OWN_BOT);
  assign vga_rdata  = vga_valid  ? mem_rdata : vga_hold;
  assign bot_rdata  = bot_rvalid ? mem_rdata : bot_hold;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pend_vga   <= 1'b0;
      starve_cnt <= '0;
      owner_p1   <= OWN_NONE;
      last_addr  <= '0;
      vga_hold   <= '0;
      bot_hold   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (vga_req) begin
        pend_vga <= 1'b1;
        if (pend_vga && !issue_vga) overrun <= 1'b1;
      end else if (issue_vga) begin
        pend_vga <= 1'b0;
      end

      if (issue_vga || issue_bot) last_addr <= mem_addr;

      if (issue_vga)                owner_p1 <= OWN_VGA;
      else if (issue_bot && !bot_we) owner_p1 <= OWN_BOT;
      else                          owner_p1 <= OWN_NONE;

      if (bot_req && !issue_bot)
        starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;

      if (vga_valid)  vga_hold <= mem_rdata;
      if (bot_rvalid) bot_hold <= mem_rdata;
    end
  end

  // Pending address is pure data; pend_vga qualifies it.
  always_ff @(posedge CLOCK_50) begin
    if (vga_req) pend_addr <= vga_addr;
  end

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Directed bench for map_mem_arbiter with a write-first synchronous RAM model
// preloaded so that cell i holds i[2:0].
module tb_map_mem_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 3;

  logic              clk;
  logic              reset;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_valid;
  logic              vga_overrun;
  logic              bot_req;
  logic              bot_we;
  logic [ADDR_W-1:0] bot_addr;
  logic [DATA_W-1:0] bot_wdata;
  logic              bot_ack;
  logic [DATA_W-1:0] bot_rdata;
  logic              bot_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  map_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(15)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_rdata  (vga_rdata),
    .vga_valid  (vga_valid),
    .vga_overrun(vga_overrun),
    .bot_req    (bot_req),
    .bot_we     (bot_we),
    .bot_addr   (bot_addr),
    .bot_wdata  (bot_wdata),
    .bot_ack    (bot_ack),
    .bot_rdata  (bot_rdata),
    .bot_rvalid (bot_rvalid),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first RAM model, one process so preload and updates never race.
  logic [DATA_W-1:0] ram [0:511];
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = DATA_W'(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven for that cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, still well before the falling edge.
  task automatic settle();
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vga_valid"},  32'(vga_valid),  0);
    chk({tag, "_bot_rvalid"}, 32'(bot_rvalid), 0);
    chk({tag, "_bot_ack"},    32'(bot_ack),    0);
    chk({tag, "_mem_we"},     32'(mem_we),     0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   0);
    chk({tag, "_mem_wdata"},  32'(mem_wdata),  0);
    chk({tag, "_overrun"},    32'(vga_overrun), 0);
    chk({tag, "_vga_rdata"},  32'(vga_rdata),  0);
    chk({tag, "_bot_rdata"},  32'(bot_rdata),  0);
  endtask

  initial begin
    reset = 1'b1; vga_req = 1'b0; vga_addr = '0;
    bot_req = 1'b0; bot_we = 1'b0; bot_addr = '0; bot_wdata = '0;
    #1;
    chk_all_zero("reset0");
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // VGA only: request cell 37 (holds 5)
    vga_req = 1'b1; vga_addr = 9'd37; settle();
    cyc(); vga_req = 1'b0; settle();
    chk("vga_issue_addr", 32'(mem_addr), 37);
    chk("vga_issue_we",   32'(mem_we), 0);
    chk("vga_issue_nvld", 32'(vga_valid), 0);
    cyc(); settle();
    chk("vga_valid",      32'(vga_valid), 1);
    chk("vga_rdata",      32'(vga_rdata), 5);
    cyc(); settle();
    chk("vga_valid_off",  32'(vga_valid), 0);
    chk("vga_rdata_hold", 32'(vga_rdata), 5);

    // Robot write 100 <- 2, then read it back
    bot_req = 1'b1; bot_we = 1'b1; bot_addr = 9'd100; bot_wdata = 3'd2; settle();
    chk("wr_ack",   32'(bot_ack), 1);
    chk("wr_we",    32'(mem_we), 1);
    chk("wr_addr",  32'(mem_addr), 100);
    chk("wr_wdata", 32'(mem_wdata), 2);
    cyc(); bot_req = 1'b0; bot_we = 1'b0; bot_wdata = '0; settle();
    chk("wr_no_rvalid", 32'(bot_rvalid), 0);
    chk("wr_ack_off",   32'(bot_ack), 0);
    cyc(); bot_req = 1'b1; settle();
    chk("rd_ack", 32'(bot_ack), 1);
    chk("rd_we",  32'(mem_we), 0);
    cyc(); bot_req = 1'b0; settle();
    chk("rd_rvalid", 32'(bot_rvalid), 1);
    chk("rd_rdata",  32'(bot_rdata), 2);

    // Collision with starve count 0: VGA first, robot next cycle
    cyc(); vga_req = 1'b1; vga_addr = 9'd37; settle();
    cyc(); vga_req = 1'b0; bot_req = 1'b1; bot_addr = 9'd6; settle();
    chk("col_vga_first_ack", 32'(bot_ack), 0);
    chk("col_vga_first_adr", 32'(mem_addr), 37);
    cyc(); settle();
    chk("col_bot_ack",  32'(bot_ack), 1);
    chk("col_bot_addr", 32'(mem_addr), 6);
    chk("col_vga_vld",  32'(vga_valid), 1);
    chk("col_vga_data", 32'(vga_rdata), 5);
    cyc(); bot_req = 1'b0; settle();
    chk("col_bot_rvld", 32'(bot_rvalid), 1);
    chk("col_bot_data", 32'(bot_rdata), 6);

    // Back-to-back robot reads of cells 10..13
    for (int i = 0; i < 4; i++) begin
      cyc(); bot_req = 1'b1; bot_addr = ADDR_W'(10 + i); settle();
      chk($sformatf("b2b_ack%0d", i), 32'(bot_ack), 1);
      chk($sformatf("b2b_adr%0d", i), 32'(mem_addr), 32'(10 + i));
      chk($sformatf("b2b_rvld%0d", i), 32'(bot_rvalid), (i > 0) ? 1 : 0);
      if (i > 0) chk($sformatf("b2b_rdat%0d", i), 32'(bot_rdata), 32'((9 + i) % 8));
    end
    cyc(); bot_req = 1'b0; settle();
    chk("b2b_ack_end",  32'(bot_ack), 0);
    chk("b2b_rvld4",    32'(bot_rvalid), 1);
    chk("b2b_rdat4",    32'(bot_rdata), 5);
    cyc(); settle();
    chk("b2b_rvld_end", 32'(bot_rvalid), 0);

    // Starvation: VGA request every cycle, robot acked in its 16th waiting cycle
    cyc(); vga_req = 1'b1; vga_addr = 9'd37; settle();
    for (int t = 0; t < 16; t++) begin
      cyc(); bot_req = 1'b1; bot_addr = 9'd20; settle();
      chk($sformatf("starve_ack_t%0d", t), 32'(bot_ack), (t == 15) ? 1 : 0);
    end
    chk("starve_addr", 32'(mem_addr), 20);
    cyc(); vga_req = 1'b0; bot_req = 1'b0; settle();
    chk("starve_displaced_adr", 32'(mem_addr), 37);
    chk("starve_bot_rvld",      32'(bot_rvalid), 1);
    chk("starve_bot_data",      32'(bot_rdata), 4);
    cyc(); settle();
    chk("starve_vga_vld",  32'(vga_valid), 1);
    chk("starve_vga_data", 32'(vga_rdata), 5);
    chk("starve_overrun",  32'(vga_overrun), 1);

    // Reset clears the sticky overrun
    cyc(); reset = 1'b1; settle();
    chk("rst_overrun_clr", 32'(vga_overrun), 0);
    cyc(); reset = 1'b0; settle();

    // Overrun: addr 5 then 6 while the robot is starved; only cell 6 returns
    cyc(); vga_req = 1'b1; vga_addr = 9'd37; settle();
    for (int t = 0; t < 14; t++) begin
      cyc(); bot_req = 1'b1; bot_addr = 9'd20; settle();
    end
    cyc(); vga_addr = 9'd5; settle();
    chk("ovr_t14_ack", 32'(bot_ack), 0);
    chk("ovr_t14_flag", 32'(vga_overrun), 0);
    cyc(); vga_addr = 9'd6; settle();
    chk("ovr_t15_ack", 32'(bot_ack), 1);
    cyc(); vga_req = 1'b0; bot_req = 1'b0; settle();
    chk("ovr_flag",     32'(vga_overrun), 1);
    chk("ovr_issue_adr", 32'(mem_addr), 6);
    chk("ovr_nvld16",   32'(vga_valid), 0);
    cyc(); settle();
    chk("ovr_vld",  32'(vga_valid), 1);
    chk("ovr_data", 32'(vga_rdata), 6);
    cyc(); settle();
    chk("ovr_single_vld", 32'(vga_valid), 0);

    // Reset mid-read: in-flight VGA response is dropped
    cyc(); vga_req = 1'b1; vga_addr = 9'd37; settle();
    cyc(); vga_req = 1'b0; settle();
    chk("midrst_issue", 32'(mem_addr), 37);
    reset = 1'b1; bot_req = 1'b1; bot_addr = 9'd50; #1;
    chk_all_zero("midrst");
    cyc(); settle();
    chk_all_zero("midrst_hold");
    bot_req = 1'b0;
    cyc(); reset = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk($sformatf("post_rst_vvld%0d", i), 32'(vga_valid), 0);
      chk($sformatf("post_rst_bvld%0d", i), 32'(bot_rvalid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
